writeback_unit: RTL and testbench

Register-file write-back controller for the MIPS core: the write-side counterpart to the instruction decode/read path. It accepts single-cycle results from the execute stage and deferred load data from the DATA RAM / I/O port, serialises them onto the register file's single write port, and keeps a per-register scoreboard so decode can stall on operands that are still in flight. Loads are tracked by destination tag in an in-order FIFO; responses return in issue order.

---
 rtl/writeback_unit.sv | 134 +++++++++++++
 tb/tb_writeback_unit.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/writeback_unit.sv
`default_nettype none
// ============================================================================
// Module   : writeback_unit
// Purpose  : Serialises ALU results and in-order load returns onto the single
//            register-file write port; keeps a per-register busy scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module writeback_unit #(
  parameter int ISA_WIDTH      = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int LD_DEPTH       = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        alu_valid,
  output logic                        alu_ready,
  input  logic [REG_ADDR_WIDTH-1:0]   alu_dest,
  input  logic [ISA_WIDTH-1:0]        alu_data,
  input  logic                        ld_issue_valid,
  output logic                        ld_issue_ready,
  input  logic [REG_ADDR_WIDTH-1:0]   ld_issue_dest,
  input  logic                        ld_rsp_valid,
  input  logic [ISA_WIDTH-1:0]        ld_rsp_data,
  input  logic [REG_ADDR_WIDTH-1:0]   rs_addr,
  input  logic [REG_ADDR_WIDTH-1:0]   rt_addr,
  output logic                        stall,
  output logic                        wb_en,
  output logic [REG_ADDR_WIDTH-1:0]   wb_addr,
  output logic [ISA_WIDTH-1:0]        wb_data,
  output logic [$clog2(LD_DEPTH):0]   ld_pending,
  output logic                        proto_err
);

  localparam int c_ptr_w = $clog2(LD_DEPTH);
  localparam int c_cnt_w = c_ptr_w + 1;
  localparam int c_nregs = 1 << REG_ADDR_WIDTH;
  localparam logic [c_cnt_w-1:0] c_depth = c_cnt_w'(LD_DEPTH);

  logic [REG_ADDR_WIDTH-1:0] r_tags [LD_DEPTH];
  logic [c_ptr_w-1:0]        r_wr_ptr;
  logic [c_ptr_w-1:0]        r_rd_ptr;
  logic [c_cnt_w-1:0]        r_count;
  logic [c_nregs-1:0]        r_busy;
  logic                      r_wb_from_load;

  logic                      w_push;
  logic                      w_pop;
  logic                      w_alu_acc;
  logic                      w_load_retire;
  logic                      w_rs_hz;
  logic                      w_rt_hz;
  logic [c_nregs-1:0]        w_busy_nxt;
  logic [REG_ADDR_WIDTH-1:0] w_head_tag;

  assign w_load_retire = wb_en && r_wb_from_load;
  assign w_head_tag    = r_tags[r_rd_ptr];

  // Issue is judged on the pre-pop count, so a full FIFO refuses issue even
  // when a response frees a slot in the same cycle.
  assign ld_issue_ready = (r_count < c_depth) && !r_busy[ld_issue_dest] &&
                          !(w_load_retire && (wb_addr == ld_issue_dest));
  assign alu_ready      = !ld_rsp_valid && !r_busy[alu_dest];

  assign w_push    = ld_issue_valid && ld_issue_ready;
  assign w_pop     = ld_rsp_valid && (r_count != '0);
  assign w_alu_acc = alu_valid && alu_ready;

  assign w_rs_hz = (rs_addr != '0) && (r_busy[rs_addr] || (wb_en && (wb_addr == rs_addr)));
  assign w_rt_hz = (rt_addr != '0) && (r_busy[rt_addr] || (wb_en && (wb_addr == rt_addr)));
  assign stall   = w_rs_hz || w_rt_hz;

  assign ld_pending = r_count;

  // Busy clears only after the load's register-file write has committed.
  always_comb begin
    w_busy_nxt = r_busy;
    if (w_load_retire) begin
      w_busy_nxt[wb_addr] = 1'b0;
    end
    if (w_push && (ld_issue_dest != '0)) begin
      w_busy_nxt[ld_issue_dest] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_tags[r_wr_ptr] <= ld_issue_dest;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      r_count        <= '0;
      r_busy         <= '0;
      r_wb_from_load <= 1'b0;
      wb_en          <= 1'b0;
      wb_addr        <= '0;
      wb_data        <= '0;
      proto_err      <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
      end
      r_count <= r_count + c_cnt_w'(w_push) - c_cnt_w'(w_pop);
      r_busy  <= w_busy_nxt;

      if (ld_rsp_valid && (r_count == '0)) begin
        proto_err <= 1'b1;
      end

      if (w_pop) begin
        wb_en          <= (w_head_tag != '0);
        wb_addr        <= w_head_tag;
        wb_data        <= ld_rsp_data;
        r_wb_from_load <= 1'b1;
      end else if (w_alu_acc) begin
        wb_en          <= (alu_dest != '0);
        wb_addr        <= alu_dest;
        wb_data        <= alu_data;
        r_wb_from_load <= 1'b0;
      end else begin
        wb_en          <= 1'b0;
        r_wb_from_load <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_writeback_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_writeback_unit
// Purpose  : Self-checking bench for writeback_unit: vector table, directed
//            multi-cycle sequences and random traffic against a queue model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_writeback_unit;

  logic        clk;
  logic        rst_n;
  logic        alu_valid;
  logic        alu_ready;
  logic [4:0]  alu_dest;
  logic [31:0] alu_data;
  logic        ld_issue_valid;
  logic        ld_issue_ready;
  logic [4:0]  ld_issue_dest;
  logic        ld_rsp_valid;
  logic [31:0] ld_rsp_data;
  logic [4:0]  rs_addr;
  logic [4:0]  rt_addr;
  logic        stall;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic [2:0]  ld_pending;
  logic        proto_err;

  int n_checks = 0;
  int n_fail   = 0;

  writeback_unit #(.ISA_WIDTH(32), .REG_ADDR_WIDTH(5), .LD_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_dest(alu_dest), .alu_data(alu_data),
    .ld_issue_valid(ld_issue_valid), .ld_issue_ready(ld_issue_ready), .ld_issue_dest(ld_issue_dest),
    .ld_rsp_valid(ld_rsp_valid), .ld_rsp_data(ld_rsp_data),
    .rs_addr(rs_addr), .rt_addr(rt_addr), .stall(stall),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .ld_pending(ld_pending), .proto_err(proto_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: pending loads as a queue of destinations, busy set,
  // and the last write-port transaction.
  logic [4:0]  m_q [$];
  logic [31:0] m_busy;
  logic        m_wb_en;
  logic        m_wb_ld;
  logic [4:0]  m_wb_addr;
  logic [31:0] m_wb_data;
  logic        m_perr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic logic m_issue_ok(input logic [4:0] d);
    return (m_q.size() < 4) && !m_busy[d] && !(m_wb_en && m_wb_ld && (m_wb_addr == d));
  endfunction

  function automatic logic m_hz(input logic [4:0] a);
    return (a != 5'd0) && (m_busy[a] || (m_wb_en && (m_wb_addr == a)));
  endfunction

  task automatic m_reset();
    m_q.delete();
    m_busy    = '0;
    m_wb_en   = 1'b0;
    m_wb_ld   = 1'b0;
    m_wb_addr = '0;
    m_wb_data = '0;
    m_perr    = 1'b0;
  endtask

  task automatic m_step();
    logic        push;
    logic        aacc;
    logic [31:0] nb;
    logic [4:0]  tag;
    push = ld_issue_valid && m_issue_ok(ld_issue_dest);
    aacc = alu_valid && !ld_rsp_valid && !m_busy[alu_dest];
    nb   = m_busy;
    if (m_wb_en && m_wb_ld) nb[m_wb_addr] = 1'b0;
    if (ld_rsp_valid) begin
      if (m_q.size() > 0) begin
        tag       = m_q.pop_front();
        m_wb_en   = (tag != 5'd0);
        m_wb_addr = tag;
        m_wb_data = ld_rsp_data;
        m_wb_ld   = 1'b1;
      end else begin
        m_perr  = 1'b1;
        m_wb_en = 1'b0;
      end
    end else if (aacc) begin
      m_wb_en   = (alu_dest != 5'd0);
      m_wb_addr = alu_dest;
      m_wb_data = alu_data;
      m_wb_ld   = 1'b0;
    end else begin
      m_wb_en = 1'b0;
    end
    if (push) begin
      m_q.push_back(ld_issue_dest);
      if (ld_issue_dest != 5'd0) nb[ld_issue_dest] = 1'b1;
    end
    m_busy = nb;
  endtask

  task automatic check_comb();
    chk("alu_ready", 32'(alu_ready), 32'(!ld_rsp_valid && !m_busy[alu_dest]));
    chk("ld_issue_ready", 32'(ld_issue_ready), 32'(m_issue_ok(ld_issue_dest)));
    chk("stall", 32'(stall), 32'(m_hz(rs_addr) || m_hz(rt_addr)));
  endtask

  task automatic check_regs();
    chk("wb_en", 32'(wb_en), 32'(m_wb_en));
    chk("wb_addr", 32'(wb_addr), 32'(m_wb_addr));
    chk("wb_data", wb_data, m_wb_data);
    chk("ld_pending", 32'(ld_pending), 32'(m_q.size()));
    chk("proto_err", 32'(proto_err), 32'(m_perr));
  endtask

  // Callers change inputs just after a rising edge, then call tick.
  task automatic tick();
    #1;
    check_comb();
    @(posedge clk);
    m_step();
    #1;
    check_regs();
  endtask

  task automatic idle();
    alu_valid      = 1'b0;
    ld_issue_valid = 1'b0;
    ld_rsp_valid   = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    m_reset();
    #1;
    check_regs();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    m_step();
    #1;
  endtask

  typedef struct {
    logic        v;
    logic [4:0]  dest;
    logic [31:0] data;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic        e_en;
    logic [4:0]  e_addr;
    logic [31:0] e_data;
    logic        e_stall;
  } vec_t;

  vec_t tbl [7];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{1'b1, 5'd8,  32'h0000_1234, 5'd8, 5'd0,  1'b1, 5'd8,  32'h0000_1234, 1'b1};
    tbl[1] = '{1'b1, 5'd8,  32'h0000_5678, 5'd9, 5'd0,  1'b1, 5'd8,  32'h0000_5678, 1'b0};
    tbl[2] = '{1'b1, 5'd0,  32'hFFFF_FFFF, 5'd0, 5'd0,  1'b0, 5'd0,  32'hFFFF_FFFF, 1'b0};
    tbl[3] = '{1'b1, 5'd31, 32'hCAFE_F00D, 5'd0, 5'd31, 1'b1, 5'd31, 32'hCAFE_F00D, 1'b1};
    tbl[4] = '{1'b1, 5'd5,  32'h0000_0005, 5'd4, 5'd5,  1'b1, 5'd5,  32'h0000_0005, 1'b1};
    tbl[5] = '{1'b0, 5'd7,  32'h0BAD_0BAD, 5'd5, 5'd0,  1'b0, 5'd5,  32'h0000_0005, 1'b0};
    tbl[6] = '{1'b1, 5'd1,  32'h8000_0001, 5'd0, 5'd0,  1'b1, 5'd1,  32'h8000_0001, 1'b0};

    rst_n = 1'b0;
    idle();
    alu_dest = '0; alu_data = '0; ld_issue_dest = '0; ld_rsp_data = '0;
    rs_addr = '0; rt_addr = '0;
    do_reset();

    // Vector table: single-cycle ALU writes and the one-cycle stall window.
    foreach (tbl[i]) begin
      alu_valid = tbl[i].v; alu_dest = tbl[i].dest; alu_data = tbl[i].data;
      rs_addr = tbl[i].rs; rt_addr = tbl[i].rt;
      #1;
      chk("tbl_alu_ready", 32'(alu_ready), 32'd1);
      tick();
      chk("tbl_wb_en", 32'(wb_en), 32'(tbl[i].e_en));
      chk("tbl_wb_addr", 32'(wb_addr), 32'(tbl[i].e_addr));
      chk("tbl_wb_data", wb_data, tbl[i].e_data);
      chk("tbl_stall", 32'(stall), 32'(tbl[i].e_stall));
    end
    idle();
    tick();

    // Load round trip to $9, response collides with an ALU write to $4.
    rs_addr = 5'd0; rt_addr = 5'd9;
    ld_issue_valid = 1'b1; ld_issue_dest = 5'd9;
    tick();
    chk("rt_ld_pending1", 32'(ld_pending), 32'd1);
    chk("rt_stall_issue", 32'(stall), 32'd1);
    idle();
    tick();
    tick();
    chk("rt_stall_wait", 32'(stall), 32'd1);
    ld_rsp_valid = 1'b1; ld_rsp_data = 32'hDEAD_BEEF;
    alu_valid = 1'b1; alu_dest = 5'd4; alu_data = 32'h0000_0444;
    #1;
    chk("col_alu_ready0", 32'(alu_ready), 32'd0);
    tick();
    chk("rt_wb_addr", 32'(wb_addr), 32'd9);
    chk("rt_wb_data", wb_data, 32'hDEAD_BEEF);
    chk("rt_ld_pending0", 32'(ld_pending), 32'd0);
    chk("rt_stall_wb", 32'(stall), 32'd1);
    ld_rsp_valid = 1'b0;
    #1;
    chk("col_alu_ready1", 32'(alu_ready), 32'd1);
    tick();
    chk("col_wb_addr", 32'(wb_addr), 32'd4);
    chk("col_wb_data", wb_data, 32'h0000_0444);
    chk("rt_stall_clear", 32'(stall), 32'd0);
    idle();
    tick();

    // Full FIFO, issue refused despite concurrent response, ALU held on $11.
    rt_addr = 5'd0;
    for (int i = 0; i < 4; i++) begin
      ld_issue_valid = 1'b1; ld_issue_dest = 5'(10 + i);
      #1;
      chk("full_issue_ready", 32'(ld_issue_ready), 32'd1);
      tick();
    end
    chk("full_pending", 32'(ld_pending), 32'd4);
    ld_issue_dest = 5'd14; ld_rsp_valid = 1'b1; ld_rsp_data = 32'h0000_00A0;
    alu_valid = 1'b1; alu_dest = 5'd11; alu_data = 32'h0000_00B0;
    #1;
    chk("full_issue_refused", 32'(ld_issue_ready), 32'd0);
    tick();
    chk("full_wb10", 32'(wb_addr), 32'd10);
    chk("full_pending3", 32'(ld_pending), 32'd3);
    ld_issue_valid = 1'b0; ld_rsp_valid = 1'b0;
    #1;
    chk("hold_alu_busy", 32'(alu_ready), 32'd0);
    tick();
    ld_rsp_valid = 1'b1; ld_rsp_data = 32'h0000_00A1;
    tick();
    chk("full_wb11_data", wb_data, 32'h0000_00A1);
    ld_rsp_valid = 1'b0;
    #1;
    chk("hold_alu_retire", 32'(alu_ready), 32'd0);
    tick();
    chk("hold_wb_idle", 32'(wb_en), 32'd0);
    #1;
    chk("hold_alu_release", 32'(alu_ready), 32'd1);
    tick();
    chk("hold_wb_data", wb_data, 32'h0000_00B0);
    alu_valid = 1'b0;
    ld_rsp_valid = 1'b1; ld_rsp_data = 32'h0000_00A2;
    tick();
    ld_rsp_data = 32'h0000_00A3;
    tick();
    idle();
    tick();
    chk("full_drained", 32'(ld_pending), 32'd0);

    // $0 destinations: no write, no busy, but the load tag is consumed.
    rs_addr = 5'd0; rt_addr = 5'd0;
    alu_valid = 1'b1; alu_dest = 5'd0; alu_data = 32'h0000_0055;
    tick();
    chk("z_alu_wb_en", 32'(wb_en), 32'd0);
    alu_valid = 1'b0;
    ld_issue_valid = 1'b1; ld_issue_dest = 5'd0;
    tick();
    chk("z_ld_pending", 32'(ld_pending), 32'd1);
    chk("z_stall", 32'(stall), 32'd0);
    ld_issue_valid = 1'b0; ld_rsp_valid = 1'b1; ld_rsp_data = 32'h0000_0066;
    tick();
    chk("z_rsp_wb_en", 32'(wb_en), 32'd0);
    chk("z_consumed", 32'(ld_pending), 32'd0);
    idle();
    tick();

    // Response with nothing outstanding.
    ld_rsp_valid = 1'b1; ld_rsp_data = 32'h0000_0099;
    tick();
    chk("perr_set", 32'(proto_err), 32'd1);
    chk("perr_no_wb", 32'(wb_en), 32'd0);
    idle();
    tick();
    tick();
    chk("perr_sticky", 32'(proto_err), 32'd1);

    // Reset with two loads in flight.
    do_reset();
    chk("rst_perr_clear", 32'(proto_err), 32'd0);
    ld_issue_valid = 1'b1; ld_issue_dest = 5'd20;
    alu_valid = 1'b1; alu_dest = 5'd3; alu_data = 32'h0000_0077;
    tick();
    alu_valid = 1'b0; ld_issue_dest = 5'd21;
    tick();
    idle();
    rs_addr = 5'd20; rt_addr = 5'd21;
    #1;
    chk("rst_pre_stall", 32'(stall), 32'd1);
    chk("rst_pre_pending", 32'(ld_pending), 32'd2);
    rst_n = 1'b0;
    m_reset();
    #1;
    chk("rst_wb_en", 32'(wb_en), 32'd0);
    chk("rst_wb_addr", 32'(wb_addr), 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    chk("rst_pending", 32'(ld_pending), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    m_step();
    #1;
    ld_rsp_valid = 1'b1; ld_rsp_data = 32'h0000_0020;
    tick();
    chk("rst_stale_rsp_perr", 32'(proto_err), 32'd1);
    do_reset();

    // Random traffic against the model.
    for (int c = 0; c < 600; c++) begin
      alu_valid      = ($urandom_range(0, 1) == 1);
      alu_dest       = 5'($urandom_range(0, 7));
      alu_data       = $urandom;
      ld_issue_valid = ($urandom_range(0, 9) < 4);
      ld_issue_dest  = 5'($urandom_range(0, 7));
      ld_rsp_valid   = (m_q.size() > 0) ? ($urandom_range(0, 9) < 4) : ($urandom_range(0, 99) == 0);
      ld_rsp_data    = $urandom;
      rs_addr        = 5'($urandom_range(0, 7));
      rt_addr        = 5'($urandom_range(0, 7));
      tick();
    end
    idle();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
